// File: rtl/iir_sos_cascade.sv
// Cascade of direct-form-I biquads sharing one multiplier: five MAC cycles
// plus one shift/saturate cycle per section, with a single sample in flight.
module iir_sos_cascade #(
    parameter int N_SECTIONS = 3,
    parameter int DATA_W     = 16,
    parameter int COEF_W     = 16,
    parameter int FRAC_W     = 14,
    parameter int ADDR_W     = $clog2(5*N_SECTIONS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     coef_we,
    input  logic [ADDR_W-1:0]        coef_addr,
    input  logic signed [COEF_W-1:0] coef_wdata,
    input  logic [3:0]               active_sec,
    input  logic                     clear_state,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     busy,
    output logic                     sat
);
    localparam int AW    = DATA_W + COEF_W + 4;
    localparam int PW    = DATA_W + COEF_W;
    localparam int SEC_W = (N_SECTIONS > 1) ? $clog2(N_SECTIONS) : 1;
    localparam logic [ADDR_W:0] N_COEF = (ADDR_W+1)'(5*N_SECTIONS);
    localparam logic signed [DATA_W-1:0] Y_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] Y_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, SAT, OUT} state_t;

    state_t state, state_next;

    logic signed [COEF_W-1:0] coef [5*N_SECTIONS];
    logic signed [DATA_W-1:0] x1 [N_SECTIONS];
    logic signed [DATA_W-1:0] x2 [N_SECTIONS];
    logic signed [DATA_W-1:0] y1 [N_SECTIONS];
    logic signed [DATA_W-1:0] y2 [N_SECTIONS];

    logic signed [DATA_W-1:0] cur_x;
    logic signed [AW-1:0]     acc;
    logic [SEC_W-1:0]         sec;
    logic [SEC_W-1:0]         last_sec;
    logic [2:0]               tap;

    logic                     accept;
    logic [3:0]               clamped;
    logic [ADDR_W-1:0]        coef_idx;
    logic signed [DATA_W-1:0] op;
    logic signed [COEF_W-1:0] coef_val;
    logic signed [PW-1:0]     prod;
    logic signed [AW-1:0]     prod_ext;
    logic signed [AW-1:0]     shifted;
    logic [AW-DATA_W:0]       upper;
    logic                     ovf;
    logic signed [DATA_W-1:0] y_sat;

    assign in_ready  = (state == IDLE) && !clear_state;
    assign accept    = in_valid && in_ready;
    assign busy      = (state != IDLE);
    assign out_valid = (state == OUT);
    assign clamped   = (active_sec > 4'(N_SECTIONS)) ? 4'(N_SECTIONS) : active_sec;

    always_comb begin
        coef_idx = ADDR_W'(5*int'(sec) + int'(tap));
        coef_val = coef[coef_idx];
        case (tap)
            3'd1:    op = x1[sec];
            3'd2:    op = x2[sec];
            3'd3:    op = y1[sec];
            3'd4:    op = y2[sec];
            default: op = cur_x;
        endcase
        prod     = op * coef_val;
        prod_ext = {{4{prod[PW-1]}}, prod};
        shifted  = acc >>> FRAC_W;
        // the value fits DATA_W only when all bits from the sign bit upward agree
        upper    = shifted[AW-1:DATA_W-1];
        ovf      = !((&upper) || !(|upper));
        if (ovf) y_sat = shifted[AW-1] ? Y_MIN : Y_MAX;
        else     y_sat = shifted[DATA_W-1:0];
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = (clamped == 4'd0) ? OUT : MAC;
            MAC:  if (tap == 3'd4) state_next = SAT;
            SAT:  state_next = (sec == last_sec) ? OUT : MAC;
            OUT:  if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 5*N_SECTIONS; i++) coef[i] <= '0;
            for (int unsigned i = 0; i < N_SECTIONS; i++) begin
                x1[i] <= '0;
                x2[i] <= '0;
                y1[i] <= '0;
                y2[i] <= '0;
            end
            cur_x    <= '0;
            acc      <= '0;
            sec      <= '0;
            last_sec <= '0;
            tap      <= '0;
            out_data <= '0;
            sat      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (coef_we && ({1'b0, coef_addr} < N_COEF)) coef[coef_addr] <= coef_wdata;
                    if (clear_state) begin
                        for (int unsigned i = 0; i < N_SECTIONS; i++) begin
                            x1[i] <= '0;
                            x2[i] <= '0;
                            y1[i] <= '0;
                            y2[i] <= '0;
                        end
                        sat <= 1'b0;
                    end else if (accept) begin
                        cur_x    <= in_data;
                        last_sec <= SEC_W'(clamped - 4'd1);
                        sec      <= '0;
                        tap      <= '0;
                        if (clamped == 4'd0) out_data <= in_data;
                    end
                end
                MAC: begin
                    // taps 3 and 4 carry the feedback terms, which are subtracted
                    case (tap)
                        3'd0:       acc <= prod_ext;
                        3'd3, 3'd4: acc <= acc - prod_ext;
                        default:    acc <= acc + prod_ext;
                    endcase
                    tap <= tap + 3'd1;
                end
                SAT: begin
                    x2[sec] <= x1[sec];
                    x1[sec] <= cur_x;
                    y2[sec] <= y1[sec];
                    y1[sec] <= y_sat;
                    cur_x   <= y_sat;
                    tap     <= '0;
                    if (ovf) sat <= 1'b1;
                    if (sec == last_sec) out_data <= y_sat;
                    else                 sec <= sec + SEC_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_iir_sos_cascade.sv
// Directed bench for iir_sos_cascade: Q2.14 coefficients, hand-computed
// outputs, latency in edges after the accept edge (0 for bypass).
module tb_iir_sos_cascade;
    localparam int N_SECTIONS = 3;
    localparam int DATA_W     = 16;
    localparam int COEF_W     = 16;
    localparam int FRAC_W     = 14;
    localparam int ADDR_W     = $clog2(5*N_SECTIONS);

    logic                     clk = 1'b0;
    logic                     reset = 1'b0;
    logic                     coef_we = 1'b0;
    logic [ADDR_W-1:0]        coef_addr = '0;
    logic signed [COEF_W-1:0] coef_wdata = '0;
    logic [3:0]               active_sec = '0;
    logic                     clear_state = 1'b0;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data = '0;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
    logic signed [DATA_W-1:0] out_data;
    logic                     busy;
    logic                     sat;

    int checks = 0;
    int errors = 0;

    iir_sos_cascade #(
        .N_SECTIONS(N_SECTIONS),
        .DATA_W    (DATA_W),
        .COEF_W    (COEF_W),
        .FRAC_W    (FRAC_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .active_sec (active_sec),
        .clear_state(clear_state),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .sat        (sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic write_coef(input int addr, input int val);
        @(negedge clk);
        coef_we    = 1'b1;
        coef_addr  = ADDR_W'(addr);
        coef_wdata = COEF_W'(val);
        @(negedge clk);
        coef_we    = 1'b0;
    endtask

    task automatic clear_pulse();
        @(negedge clk);
        clear_state = 1'b1;
        @(negedge clk);
        clear_state = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic send(input int x, input int nsec, output logic signed [DATA_W-1:0] y, output int lat);
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        in_valid   = 1'b1;
        in_data    = DATA_W'(x);
        active_sec = 4'(nsec);
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(lat);
        y = out_data;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_drop", out_valid, 0);
        check("busy_drop", busy, 0);
    endtask

    task automatic run(input string tag, input int x, input int nsec, input int y_exp, input int lat_exp);
        logic signed [DATA_W-1:0] y;
        int lat;
        send(x, nsec, y, lat);
        check({tag, "_lat"}, lat, lat_exp);
        check({tag, "_y"}, y, y_exp);
        handshake();
    endtask

    initial begin
        logic signed [DATA_W-1:0] y;
        int lat;

        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_sat", sat, 0);
        check("rst_busy", busy, 0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);

        // single pass-through section
        write_coef(0, 16384);
        run("t1", 1000, 1, 1000, 6);

        // clear + coefficient write + offered sample in one cycle: no accept, write lands
        @(negedge clk);
        clear_state = 1'b1;
        coef_we     = 1'b1;
        coef_addr   = ADDR_W'(3);
        coef_wdata  = COEF_W'(-8192);
        in_valid    = 1'b1;
        in_data     = DATA_W'(777);
        active_sec  = 4'd1;
        #1 check("clr_in_ready", in_ready, 0);
        @(negedge clk);
        clear_state = 1'b0;
        coef_we     = 1'b0;
        in_valid    = 1'b0;
        check("clr_no_accept", busy, 0);

        // feedback a1=-0.5, with a bypass sample in the middle leaving sec0 untouched
        run("t2a", 8192, 1, 8192, 6);
        run("t4_bypass", -5, 0, -5, 0);
        run("t2b", 0, 1, 4096, 6);
        run("t2c", 0, 1, 2048, 6);

        // saturation, sticky flag, clear
        clear_pulse();
        write_coef(3, 0);
        write_coef(0, 32767);
        run("t3_pos", 30000, 1, 32767, 6);
        check("t3_sat_set", sat, 1);
        run("t3_neg", -30000, 1, -32768, 6);
        check("t3_sat_sticky", sat, 1);
        clear_pulse();
        check("t3_sat_clr", sat, 0);

        // floor rounding: 0.5 * -3 = -1.5 -> -2
        write_coef(0, 8192);
        run("floor", -3, 1, -2, 6);
        check("floor_no_sat", sat, 0);

        // two sections, output held under backpressure
        write_coef(0, 16384);
        write_coef(5, 8192);
        send(4000, 2, y, lat);
        check("t5_lat", lat, 12);
        check("t5_y", y, 2000);
        in_valid   = 1'b1;
        in_data    = DATA_W'(1234);
        active_sec = 4'd1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, 2000);
            check("hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        handshake();

        // active_sec above N_SECTIONS clamps to 3
        write_coef(10, 4096);
        run("clamp", 4000, 9, 500, 18);

        // coefficient write while busy must be dropped
        send(1000, 1, y, lat);
        check("pre_mac_y", y, 1000);
        handshake();
        @(negedge clk);
        in_valid   = 1'b1;
        in_data    = DATA_W'(1000);
        active_sec = 4'd1;
        @(negedge clk);
        in_valid   = 1'b0;
        coef_we    = 1'b1;
        coef_addr  = ADDR_W'(0);
        coef_wdata = '0;
        @(negedge clk);
        coef_we = 1'b0;
        wait_valid(lat);
        check("mac_we_y", out_data, 1000);
        handshake();
        run("mac_we_readback", 1000, 1, 1000, 6);

        // asynchronous reset during section 1 MAC
        @(negedge clk);
        in_valid   = 1'b1;
        in_data    = DATA_W'(4000);
        active_sec = 4'd2;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        check("mid_busy", busy, 1);
        reset = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_out_data", out_data, 0);
        check("arst_sat", sat, 0);
        @(negedge clk);
        reset = 1'b1;
        run("post_rst_zero_coef", 1000, 1, 0, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
